lic_mtimer: RTL

- Parametrised successor to the single-channel local timer.
- Provides one free-running 64-bit mtime counter, a programmable prescaler and NCH independent 64-bit mtimecmp channels, each with its own maskable timer interrupt.
- Registers are reached through a simple word-addressed read/write port driven by the CSR/LSU decode logic.
- Sits beside the core CSR unit; each channel's registered irq feeds one hart's mtip input.

---
 rtl/lic_mtimer.sv | 67 ++++++
 1 files changed

// File: rtl/lic_mtimer.sv
// lic_mtimer: 64-bit mtime with prescaler and NCH maskable mtimecmp interrupt channels
module lic_mtimer #(
    parameter int XLEN    = 32,
    parameter int NCH     = 2,
    parameter int PRESC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lic_wr_ena,
    input  logic [4:0]      lic_addr,
    input  logic [XLEN-1:0] lic_wr_data,
    output logic [XLEN-1:0] lic_rd_data,
    input  logic [NCH-1:0]  csr_mtie_r,
    output logic [NCH-1:0]  lic_tmr_irq_r
);
    localparam bit WIDE = (XLEN == 64);
    logic [63:0] mtime, wd, rd;
    logic [63:0] cmp [NCH];
    logic [PRESC_W-1:0] presc, pcnt;
    logic en, tick, wr_lo, wr_hi, wr_presc, wr_ctrl;
    assign wd = 64'(lic_wr_data);
    assign wr_lo = lic_wr_ena && lic_addr == 5'd0;
    assign wr_hi = lic_wr_ena && lic_addr == 5'd1 && !WIDE;
    assign wr_presc = lic_wr_ena && lic_addr == 5'd2;
    assign wr_ctrl = lic_wr_ena && lic_addr == 5'd3;
    assign tick = en && pcnt == presc;
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime <= '0;
            presc <= '0;
            en <= 1'b1;
            pcnt <= '0;
        end else begin
            mtime <= wr_lo ? (WIDE ? wd : {mtime[63:32], wd[31:0]}) :
                     wr_hi ? {wd[31:0], mtime[31:0]} : mtime + 64'(tick);
            if (wr_presc) presc <= wd[PRESC_W-1:0];
            if (wr_ctrl) en <= wd[0];
            pcnt <= (wr_presc || wr_ctrl || tick) ? '0 : pcnt + PRESC_W'(en);
        end
    end
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                cmp[c] <= '1;
                lic_tmr_irq_r[c] <= 1'b0;
            end else begin
                if (lic_wr_ena && lic_addr == 5'(4 + 2 * c))
                    cmp[c] <= WIDE ? wd : {cmp[c][63:32], wd[31:0]};
                else if (lic_wr_ena && lic_addr == 5'(5 + 2 * c) && !WIDE)
                    cmp[c] <= {wd[31:0], cmp[c][31:0]};
                lic_tmr_irq_r[c] <= mtime >= cmp[c] && csr_mtie_r[c];
            end
        end
    end
    always_comb begin
        rd = '0;
        if (lic_addr == 5'd0) rd = WIDE ? mtime : {32'b0, mtime[31:0]};
        if (lic_addr == 5'd1 && !WIDE) rd = {32'b0, mtime[63:32]};
        if (lic_addr == 5'd2) rd = 64'(presc);
        if (lic_addr == 5'd3) rd = {63'b0, en};
        for (int c = 0; c < NCH; c++) begin
            if (lic_addr == 5'(4 + 2 * c)) rd = WIDE ? cmp[c] : {32'b0, cmp[c][31:0]};
            if (lic_addr == 5'(5 + 2 * c) && !WIDE) rd = {32'b0, cmp[c][63:32]};
        end
    end
    assign lic_rd_data = rd[XLEN-1:0];
endmodule
